// File: rtl/benes_cfg_sched.sv
// Configuration scheduler for an 8x8 Benes network: holds one pending config, applies it, streams N beats, drains.
// Optional: define CFG_PARITY_CHK_EN to drop configs with bad even parity and raise sticky cfg_err.
module benes_cfg_sched #(
    parameter int NUM_STAGES   = 5,
    parameter int SW_PER_STAGE = 4,
    parameter int CFG_W        = NUM_STAGES*SW_PER_STAGE,
    parameter int LEN_W        = 8,
    parameter int DRAIN_CYC    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_parity,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [CFG_W-1:0] switch_set,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);
    localparam int DRN_W = $clog2(DRAIN_CYC+1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    state_t             r_state, w_next;
    logic               r_pend_valid;
    logic [CFG_W-1:0]   r_pend_cfg;
    logic [LEN_W-1:0]   r_pend_len;
    logic [LEN_W:0]     r_beat_cnt;
    logic [DRN_W-1:0]   r_drain_cnt;
    logic [CFG_W-1:0]   r_switch_set;

    logic w_accept, w_par_bad, w_store, w_frame_end, w_load, w_beat, w_last;

    assign w_accept    = cfg_valid & ~r_pend_valid;
    assign w_store     = w_accept & ~w_par_bad;
    assign w_frame_end = (r_state == S_DRAIN) && (r_drain_cnt == DRN_W'(1));
    assign w_load      = r_pend_valid && ((r_state == S_IDLE) || w_frame_end);
    assign w_beat      = (r_state == S_STREAM) && src_valid;
    assign w_last      = w_beat && (r_beat_cnt == (LEN_W+1)'(1));

`ifdef CFG_PARITY_CHK_EN
    logic r_cfg_err;
    assign w_par_bad = ^{cfg_data, cfg_parity};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_cfg_err <= 1'b0;
        else if (w_accept && w_par_bad) r_cfg_err <= 1'b1;
    end
    assign cfg_err = r_cfg_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = cfg_parity;
    assign w_par_bad       = 1'b0;
    assign cfg_err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_pend_valid) w_next = S_LOAD;
            S_LOAD:   w_next = S_STREAM;
            S_STREAM: if (w_last) w_next = S_DRAIN;
            S_DRAIN:  if (w_frame_end) w_next = r_pend_valid ? S_LOAD : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Loading and accepting are exclusive: cfg_ready is low whenever an entry is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_cfg   <= '0;
            r_pend_len   <= '0;
        end else if (w_load) begin
            r_pend_valid <= 1'b0;
        end else if (w_store) begin
            r_pend_valid <= 1'b1;
            r_pend_cfg   <= cfg_data;
            r_pend_len   <= cfg_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_switch_set <= '0;
            r_beat_cnt   <= '0;
        end else if (w_load) begin
            r_switch_set <= r_pend_cfg;
            r_beat_cnt   <= (r_pend_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, r_pend_len};
        end else if (w_beat) begin
            r_beat_cnt   <= r_beat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        r_drain_cnt <= '0;
        else if (w_last)                                r_drain_cnt <= DRN_W'(DRAIN_CYC);
        else if (r_state == S_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
    end

    assign cfg_ready  = ~r_pend_valid;
    assign src_ready  = (r_state == S_STREAM);
    assign switch_set = r_switch_set;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_frame_end;
endmodule

// File: tb/tb_benes_cfg_sched.sv
// Self-checking bench for benes_cfg_sched: cycle-exact scenario tasks plus a frame scoreboard.
module tb_benes_cfg_sched;
    localparam logic [19:0] CFG_S = 20'h8_4321;
    localparam logic [19:0] CFG_G = 20'h1_2345;
    localparam logic [19:0] CFG_A = 20'h0_1234;
    localparam logic [19:0] CFG_B = 20'hF_0F0F;

    logic        clk = 0, rst = 1;
    logic        cfg_valid = 0, cfg_parity = 0, src_valid = 0;
    logic [19:0] cfg_data = '0;
    logic [7:0]  cfg_len = '0;
    logic        cfg_ready, src_ready, busy, frame_done, cfg_err;
    logic [19:0] switch_set;

    int checks = 0, errors = 0, mon_beats = 0;

    typedef struct { logic [19:0] cfg; int beats; } exp_t;
    exp_t sb[$];

    benes_cfg_sched dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_parity(cfg_parity),
        .src_valid(src_valid), .src_ready(src_ready), .switch_set(switch_set),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Frame scoreboard: every frame_done must match the oldest expected config and beat count.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) mon_beats = 0;
        else begin
            if (src_valid && src_ready) mon_beats++;
            if (frame_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_frame: unexpected frame_done, switch_set=%h beats=%0d", switch_set, mon_beats);
                end else begin
                    e = sb.pop_front();
                    if (switch_set !== e.cfg || mon_beats != e.beats) begin
                        errors++;
                        $display("FAIL sb_frame: got cfg=%h beats=%0d, exp cfg=%h beats=%0d",
                                 switch_set, mon_beats, e.cfg, e.beats);
                    end
                end
                mon_beats = 0;
            end
        end
    end

    // Offers a config; returns at the negedge before the accepting edge with cfg_valid still high.
    task automatic send_cfg(input logic [19:0] d, input logic [7:0] l);
        exp_t e;
        @(posedge clk); #1;
        cfg_valid = 1; cfg_data = d; cfg_len = l; cfg_parity = ^d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                e.cfg = d; e.beats = (l == 0) ? 256 : int'(l);
                sb.push_back(e);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL cfg_accept: cfg_ready got 0 for 50 cycles, exp 1");
        cfg_valid = 0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++; errors++;
        $display("FAIL wait_idle: busy got 1 after %0d cycles, exp 0", max);
    endtask

    task automatic test_reset();
        src_valid = 1;
        send_cfg(20'h5_5555, 3);
        @(posedge clk); #1; cfg_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1; #1;
        checks++;
        if ({switch_set, src_ready, cfg_ready, busy, frame_done, cfg_err} !== {20'h0, 5'b01000}) begin
            errors++;
            $display("FAIL reset_vals: got sw=%h rdy=%b crdy=%b busy=%b fd=%b err=%b, exp 00000 0 1 0 0 0",
                     switch_set, src_ready, cfg_ready, busy, frame_done, cfg_err);
        end
        sb.delete();
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        checks++;
        if ({cfg_ready, busy, switch_set} !== {2'b10, 20'h0}) begin
            errors++;
            $display("FAIL reset_release: got crdy=%b busy=%b sw=%h, exp 1 0 00000", cfg_ready, busy, switch_set);
        end
    endtask

    task automatic test_single();
        logic [23:0] got, exp;
        src_valid = 1;
        send_cfg(CFG_S, 3);
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 0) cfg_valid = 0;
            @(negedge clk);
            got = {switch_set, src_ready, frame_done, busy, cfg_ready};
            exp = {(k >= 1) ? CFG_S : 20'h0, (k >= 2 && k <= 4), (k == 9), (k >= 1 && k <= 9), (k != 0)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single k=%0d: got {sw,rdy,fd,busy,crdy}=%h exp %h", k, got, exp);
            end
        end
    endtask

    task automatic test_gapped();
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int beats = 0;
        src_valid = 0;
        send_cfg(CFG_G, 4);
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 0) cfg_valid = 0;
            if (k >= 2 && k <= 8) src_valid = (pat[k-2] != 0);
            if (k == 9) src_valid = 0;
            @(negedge clk);
            if (src_valid && src_ready) beats++;
            checks++;
            if (k <= 8 && src_ready !== (k >= 2)) begin
                errors++;
                $display("FAIL gapped_rdy k=%0d: got %b exp %b", k, src_ready, (k >= 2));
            end else if (k == 9 && {src_ready, busy} !== 2'b01) begin
                errors++;
                $display("FAIL gapped_drain: got {rdy,busy}=%b exp 01", {src_ready, busy});
            end
        end
        checks++;
        if (beats != 4) begin
            errors++;
            $display("FAIL gapped_beats: got %0d exp 4", beats);
        end
        wait_idle(20);
    endtask

    task automatic test_back_to_back();
        logic [23:0] got, exp;
        exp_t e;
        src_valid = 1;
        send_cfg(CFG_A, 2);
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 0) cfg_valid = 0;
            if (k == 2) begin
                cfg_valid = 1; cfg_data = CFG_B; cfg_len = 1; cfg_parity = ^CFG_B;
                e.cfg = CFG_B; e.beats = 1; sb.push_back(e);
            end
            if (k == 3) cfg_valid = 0;
            @(negedge clk);
            got = {switch_set, src_ready, frame_done, busy, cfg_ready};
            exp = {(k == 0) ? CFG_G : (k <= 8) ? CFG_A : CFG_B,
                   (k == 2 || k == 3 || k == 10), (k == 8 || k == 15),
                   (k >= 1 && k <= 15), !(k == 0 || (k >= 3 && k <= 8))};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b k=%0d: got {sw,rdy,fd,busy,crdy}=%h exp %h", k, got, exp);
            end
        end
    endtask

    task automatic test_len0();
        int beats = 0, fds = 0, last = -1, fdc = -1;
        bit done = 0;
        src_valid = 1;
        send_cfg(20'h0_00FF, 0);
        @(posedge clk); #1; cfg_valid = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (src_valid && src_ready) begin beats++; last = c; end
            if (frame_done) begin fds++; fdc = c; end
            if (fds > 0 && !busy) done = 1;
        end
        checks++;
        if (beats != 256 || fds != 1 || fdc - last != 5 || !done) begin
            errors++;
            $display("FAIL len0: got beats=%0d fd=%0d drain=%0d idle=%0d, exp 256 1 5 1",
                     beats, fds, fdc - last, done);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        src_valid = 1;
        send_cfg(20'h3_3333, 5);
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) cfg_valid = 0;
            if (k == 2) begin
                cfg_valid = 1; cfg_data = 20'h7_7777; cfg_len = 1; cfg_parity = ^cfg_data;
                e.cfg = 20'h7_7777; e.beats = 1; sb.push_back(e);
            end
            if (k == 3) cfg_valid = 0;
        end
        @(negedge clk); #2 rst = 1; #1;
        checks++;
        if ({switch_set, src_ready, cfg_ready, busy, frame_done} !== {20'h0, 4'b0100}) begin
            errors++;
            $display("FAIL rst_mid: got sw=%h rdy=%b crdy=%b busy=%b fd=%b, exp 00000 0 1 0 0",
                     switch_set, src_ready, cfg_ready, busy, frame_done);
        end
        sb.delete();
        repeat (3) @(posedge clk);
        #3 rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, switch_set} !== 21'h0) begin
                errors++;
                $display("FAIL rst_mid_lost k=%0d: got busy=%b sw=%h, exp 0 00000", k, busy, switch_set);
            end
        end
        send_cfg(20'h0_BEEF, 2);
        @(posedge clk); #1; cfg_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({switch_set, busy} !== {20'h0_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_reload: got sw=%h busy=%b, exp 0beef 1", switch_set, busy);
        end
        wait_idle(20);
    endtask

`ifdef CFG_PARITY_CHK_EN
    task automatic test_parity();
        @(posedge clk); #1;
        cfg_valid = 1; cfg_data = 20'h0_0001; cfg_len = 1; cfg_parity = 0;
        @(posedge clk); #1; cfg_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({cfg_err, cfg_ready, busy} !== 3'b110) begin
                errors++;
                $display("FAIL parity_drop k=%0d: got {err,crdy,busy}=%b exp 110", k, {cfg_err, cfg_ready, busy});
            end
        end
        send_cfg(20'h0_0003, 1);
        @(posedge clk); #1; cfg_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({switch_set, cfg_err} !== {20'h0_0003, 1'b1}) begin
            errors++;
            $display("FAIL parity_good: got sw=%h err=%b, exp 00003 1", switch_set, cfg_err);
        end
        wait_idle(20);
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        test_reset();
        test_single();
        test_gapped();
        test_back_to_back();
        test_len0();
        test_reset_mid();
`ifdef CFG_PARITY_CHK_EN
        test_parity();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames outstanding, exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/benes_cfg_sched.md
Name: benes_cfg_sched

Overview:
- Configuration scheduler for the 8x8 Benes network built from 2x2 switch_module cells: 5 stages x 4 switches = 20 switch_set bits.
- Accepts precomputed permutation configurations over a valid/ready handshake and holds one pending entry.
- Applies each configuration to all switches at once, then admits a fixed number of data beats into the network.
- Before loading the next configuration, it waits for the network pipeline to drain, so in-flight beats never see a switch change.

Parameters:
- NUM_STAGES, 5, Benes stages (2*log2(8)-1)
- SW_PER_STAGE, 4, 2x2 switches per stage
- CFG_W, 20, NUM_STAGES*SW_PER_STAGE; width of the configuration word
- LEN_W, 8, width of the beat-count field
- DRAIN_CYC, 5, network pipeline depth in cycles (one register per stage)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  pending slot empty; equals ~pend_valid
- cfg_data  in  CFG_W  bit [s*SW_PER_STAGE+k] = stage s, switch k; 1 = cross, 0 = bar
- cfg_len  in  LEN_W  data beats under this config; 0 means 2^LEN_W
- cfg_parity  in  1  even parity over cfg_data; used only with CFG_PARITY_CHK_EN
- src_valid  in  1  upstream data beat available
- src_ready  out  1  network admitting beats
- switch_set  out  CFG_W  registered drive to all switch_module switch_set inputs
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when a frame has fully drained
- cfg_err  out  1  sticky parity error; constant 0 without the feature

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: switch_set=0 (all bar), src_ready=0, busy=0, frame_done=0, cfg_err=0. pend_valid=0, so cfg_ready=1. State=IDLE.
- Reset mid-operation: the pending entry and all counters are discarded. switch_set returns to 0 immediately (asynchronous).
- Accept: cfg_valid & cfg_ready at a clock edge captures cfg_data/cfg_len into the pending register and sets pend_valid.
- Pending slot: holds one entry only. cfg_ready is low while it is full, including during the cycle the entry is consumed.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - src_ready=0.
  - If pend_valid, go to LOAD on the next edge: switch_set <= pend_cfg, beat_cnt <= pend_len (0 -> 2^LEN_W), pend_valid <= 0.
- LOAD:
  - Exactly 1 cycle of switch settle; src_ready=0.
  - Always goes to STREAM.
- STREAM:
  - src_ready=1 (combinational from state).
  - Each cycle with src_valid & src_ready decrements beat_cnt. Cycles without src_valid do not count.
  - On acceptance of the last beat (beat_cnt==1): go to DRAIN, drain_cnt <= DRAIN_CYC.
- DRAIN:
  - src_ready=0; drain_cnt decrements each cycle.
  - In the cycle drain_cnt==1, frame_done=1. Next state is LOAD if pend_valid, else IDLE, so back-to-back frames have no IDLE gap.
- switch_set changes only on the IDLE->LOAD or DRAIN->LOAD transition. It holds its value in IDLE after a frame completes.
- Simultaneous acceptance and consumption: a new cfg accepted in the same cycle as DRAIN->LOAD cannot occur, because cfg_ready=0 while pend_valid=1.
- Latency: from an accepting edge with the scheduler in IDLE:
  - switch_set valid 1 cycle later (LOAD);
  - src_ready high 2 cycles later.
- Counters: beat_cnt is LEN_W+1 bits wide so it can hold 2^LEN_W. drain_cnt is $clog2(DRAIN_CYC+1) bits wide.

Optional Feature:
- Macro: CFG_PARITY_CHK_EN.
- Defined: at acceptance, a config with ^{cfg_data,cfg_parity}!=0 is dropped (pend_valid stays 0) and cfg_err is set. cfg_err is sticky until rst.
- Undefined: cfg_parity is ignored, every handshake is stored, and cfg_err is tied to 0.

Test Plan:
- Reset: assert rst for 3 cycles mid-clock -> switch_set=0, src_ready=0, cfg_ready=1, busy=0, frame_done=0, checked immediately, before any clock edge.
- Single frame: cfg_data=20'h8_4321, cfg_len=3, src_valid held 1, accepted at edge T ->
  - switch_set=20'h84321 from T+1;
  - src_ready=1 for exactly cycles T+2..T+4;
  - DRAIN T+5..T+9, frame_done pulse at T+9;
  - busy=0 from T+10.
- Gapped source: cfg_len=4, src_valid pattern 1,0,0,1,1,0,1 -> src_ready stays high through all 7 STREAM cycles and exactly 4 beats are accepted. DRAIN is entered after the 7th STREAM cycle.
- Back-to-back: cfg A (len 2) accepted, then cfg B (20'hF_0F0F) accepted during STREAM ->
  - cfg_ready=0 until B enters LOAD;
  - switch_set stays A through the entire DRAIN;
  - B is loaded in the cycle after A's frame_done, with no IDLE cycle.
- Boundary length: cfg_len=0, src_valid held 1 -> exactly 256 beats accepted, then 5 drain cycles and one frame_done.
- Reset mid-STREAM after 2 of 5 beats, with a pending cfg present -> all outputs return to reset values and the pending entry is lost. A new cfg after reset loads normally.
- (CFG_PARITY_CHK_EN) cfg_data=20'h00001 with cfg_parity=0 -> not loaded, cfg_err=1 and stays 1. A following cfg with correct parity loads normally.
